layer_address_sequencer: RTL

- Parametrised successor to the single-layer address calculation unit.
- Accepts one screen-pixel request and scans NUM_LAYERS layer register sets in index order.
- For every layer covering that pixel, emits one record on a valid/ready stream: layer-local coordinates plus the RAM byte offset (sprite layers) or flash bit offset (font layers).
- Sits between the pixel scan counter and the memory fetch stage.

---
 rtl/gpu_layer_pkg.sv | 44 ++++
 rtl/layer_hit_test.sv | 42 ++++
 rtl/layer_address_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gpu_layer_pkg.sv
// Shared layer register layout, field unpacking and sequencer state encoding
// for the layer address sequencer.
package gpu_layer_pkg;

  localparam int LAYER_BITS    = 128;
  localparam int POPULATED_BIT = 0;
  localparam int SPRITE_BIT    = 1;
  localparam int WIDTH_LSB     = 16;
  localparam int HEIGHT_LSB    = 32;
  localparam int XPOS_LSB      = 48;
  localparam int YPOS_LSB      = 64;
  localparam int CHARS_LSB     = 96;

  typedef struct packed {
    logic        populated;
    logic        isSprite;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] xPosition;
    logic [15:0] yPosition;
    logic [3:0]  numChars;
  } layer_fields_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CALC,
    ST_EMIT,
    ST_EMIT_END
  } seq_state_t;

  function automatic layer_fields_t unpack_layer(input logic [LAYER_BITS-1:0] regs);
    layer_fields_t f;
    f.populated = regs[POPULATED_BIT];
    f.isSprite  = regs[SPRITE_BIT];
    f.width     = regs[WIDTH_LSB +: 16];
    f.height    = regs[HEIGHT_LSB +: 16];
    f.xPosition = regs[XPOS_LSB +: 16];
    f.yPosition = regs[YPOS_LSB +: 16];
    f.numChars  = regs[CHARS_LSB +: 4];
    return f;
  endfunction

endpackage

// File: rtl/layer_hit_test.sv
// Combinational coverage test of one layer against a screen pixel, plus the
// pixel's coordinates relative to the layer origin.
module layer_hit_test
  import gpu_layer_pkg::*;
#(
  parameter int COORD_W = 9
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  layer_fields_t      i_layer,
  output logic               o_hit,
  output logic [15:0]        o_layerX,
  output logic [15:0]        o_layerY
);

  // 21 bits holds xPosition + width*15 without wrapping.
  logic [20:0] w_x;
  logic [20:0] w_y;
  logic [20:0] w_extent;
  logic [20:0] w_xEnd;
  logic [20:0] w_yEnd;
  logic        w_shapeOk;

  assign w_x      = 21'(i_x);
  assign w_y      = 21'(i_y);
  assign w_extent = i_layer.isSprite ? 21'(i_layer.width)
                                     : 21'(i_layer.width) * 21'(i_layer.numChars);
  assign w_xEnd   = 21'(i_layer.xPosition) + w_extent;
  assign w_yEnd   = 21'(i_layer.yPosition) + 21'(i_layer.height);

  assign w_shapeOk = i_layer.populated && (i_layer.width != 16'd0) &&
                     (i_layer.height != 16'd0) &&
                     (i_layer.isSprite || (i_layer.numChars != 4'd0));

  assign o_hit = w_shapeOk &&
                 (w_x >= 21'(i_layer.xPosition)) && (w_x < w_xEnd) &&
                 (w_y >= 21'(i_layer.yPosition)) && (w_y < w_yEnd);

  assign o_layerX = 16'(w_x) - i_layer.xPosition;
  assign o_layerY = 16'(w_y) - i_layer.yPosition;

endmodule

// File: rtl/layer_address_sequencer.sv
// Scans all layer register sets for one pixel request and streams one record
// per covering layer, with sprite RAM byte offsets or font flash bit offsets.
module layer_address_sequencer
  import gpu_layer_pkg::*;
#(
  parameter int NUM_LAYERS    = 8,
  parameter int COORD_W       = 9,
  parameter int BPP_BYTES     = 2,
  parameter int FONT_BPP_BITS = 1,
  parameter int RAM_ADDR_W    = 27,
  parameter int FLASH_ADDR_W  = 30
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [COORD_W-1:0]              x_pixel,
  input  logic [COORD_W-1:0]              y_pixel,
  input  logic [NUM_LAYERS*LAYER_BITS-1:0] layer_regs,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_hit,
  output logic                            out_last,
  output logic [$clog2(NUM_LAYERS)-1:0]   out_layer,
  output logic                            out_is_sprite,
  output logic [15:0]                     out_layer_x,
  output logic [15:0]                     out_layer_y,
  output logic [3:0]                      out_char_idx,
  output logic [RAM_ADDR_W-1:0]           out_ram_offset,
  output logic [FLASH_ADDR_W-1:0]         out_flash_offset,
  output logic                            busy
);

  localparam int                    LAYER_W    = $clog2(NUM_LAYERS);
  localparam logic [LAYER_W-1:0]    LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam int                    PROD_W     = 48;

  seq_state_t              r_state;
  logic [COORD_W-1:0]      r_x;
  logic [COORD_W-1:0]      r_y;
  logic [LAYER_W-1:0]      r_layerK;
  logic [15:0]             r_layerX;
  logic [15:0]             r_layerY;
  logic [15:0]             r_col;
  logic [3:0]              r_charIdx;
  logic                    r_outValid;
  logic                    r_outHit;
  logic                    r_outLast;
  logic                    r_outIsSprite;
  logic [15:0]             r_outLayerX;
  logic [15:0]             r_outLayerY;
  logic [3:0]              r_outCharIdx;
  logic [RAM_ADDR_W-1:0]   r_outRamOffset;
  logic [FLASH_ADDR_W-1:0] r_outFlashOffset;

  layer_fields_t           w_layer;
  logic                    w_hit;
  logic [15:0]             w_layerX;
  logic [15:0]             w_layerY;
  logic [PROD_W-1:0]       w_ramFull;
  logic [PROD_W-1:0]       w_flashFull;
  logic                    w_calcDone;

  assign w_layer = unpack_layer(layer_regs[int'(r_layerK)*LAYER_BITS +: LAYER_BITS]);

  layer_hit_test #(
    .COORD_W (COORD_W)
  ) u_hitTest (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_layer  (w_layer),
    .o_hit    (w_hit),
    .o_layerX (w_layerX),
    .o_layerY (w_layerY)
  );

  assign w_ramFull = (PROD_W'(r_layerY) * PROD_W'(w_layer.width) + PROD_W'(r_layerX))
                     * PROD_W'(BPP_BYTES);
  assign w_flashFull = (PROD_W'(r_charIdx) * PROD_W'(w_layer.width) * PROD_W'(w_layer.height)
                        + PROD_W'(r_layerY) * PROD_W'(w_layer.width) + PROD_W'(r_col))
                       * PROD_W'(FONT_BPP_BITS);
  // Font column reduction ends once the remaining column fits inside one glyph.
  assign w_calcDone = w_layer.isSprite || (r_col < w_layer.width);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_x              <= '0;
      r_y              <= '0;
      r_layerK         <= '0;
      r_layerX         <= '0;
      r_layerY         <= '0;
      r_col            <= '0;
      r_charIdx        <= '0;
      r_outValid       <= 1'b0;
      r_outHit         <= 1'b0;
      r_outLast        <= 1'b0;
      r_outIsSprite    <= 1'b0;
      r_outLayerX      <= '0;
      r_outLayerY      <= '0;
      r_outCharIdx     <= '0;
      r_outRamOffset   <= '0;
      r_outFlashOffset <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_x      <= x_pixel;
            r_y      <= y_pixel;
            r_layerK <= '0;
            r_state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_layerX  <= w_layerX;
            r_layerY  <= w_layerY;
            r_col     <= w_layerX;
            r_charIdx <= '0;
            r_state   <= ST_CALC;
          end else if (r_layerK == LAST_LAYER) begin
            r_outValid       <= 1'b1;
            r_outHit         <= 1'b0;
            r_outLast        <= 1'b1;
            r_outIsSprite    <= 1'b0;
            r_outLayerX      <= '0;
            r_outLayerY      <= '0;
            r_outCharIdx     <= '0;
            r_outRamOffset   <= '0;
            r_outFlashOffset <= '0;
            r_state          <= ST_EMIT_END;
          end else begin
            r_layerK <= r_layerK + 1'b1;
          end
        end
        ST_CALC: begin
          if (w_calcDone) begin
            r_outValid       <= 1'b1;
            r_outHit         <= 1'b1;
            r_outLast        <= (r_layerK == LAST_LAYER);
            r_outIsSprite    <= w_layer.isSprite;
            r_outLayerX      <= r_layerX;
            r_outLayerY      <= r_layerY;
            r_outCharIdx     <= w_layer.isSprite ? 4'd0 : r_charIdx;
            r_outRamOffset   <= w_layer.isSprite ? RAM_ADDR_W'(w_ramFull) : '0;
            r_outFlashOffset <= w_layer.isSprite ? '0 : FLASH_ADDR_W'(w_flashFull);
            r_state          <= ST_EMIT;
          end else begin
            r_col     <= r_col - w_layer.width;
            r_charIdx <= r_charIdx + 1'b1;
          end
        end
        ST_EMIT, ST_EMIT_END: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            if (r_outLast) begin
              r_state <= ST_IDLE;
            end else begin
              r_layerK <= r_layerK + 1'b1;
              r_state  <= ST_SCAN;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready        = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign out_valid        = r_outValid;
  assign out_hit          = r_outHit;
  assign out_last         = r_outLast;
  assign out_layer        = r_layerK;
  assign out_is_sprite    = r_outIsSprite;
  assign out_layer_x      = r_outLayerX;
  assign out_layer_y      = r_outLayerY;
  assign out_char_idx     = r_outCharIdx;
  assign out_ram_offset   = r_outRamOffset;
  assign out_flash_offset = r_outFlashOffset;

endmodule
